// File: rtl/conv_addr_gen_pkg.sv
// Shared definitions for the convolution window address generator.
package conv_addr_gen_pkg;

  // Native register width of the CSR block feeding this sequencer.
  localparam int XLEN = 32;

  // Default loop counter width; every layer dimension must fit in it.
  localparam int CNT_W_DEF = 16;

  // Number of nested loops: kx, ky, ci, ox, oy, co (innermost first).
  localparam int N_LOOPS = 6;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_loop_cnt.sv
// Wrap counter for one loop level. Counts 0..limit on en and reports when it
// sits at its maximum; wrap marks the enabled step that rolls it back to 0
// and feeds the en of the next outer loop.
module conv_loop_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         max,
  output logic         wrap
);

  logic [W-1:0] count;

  assign max  = (count == limit);
  assign wrap = en & max;

  // Advance on en, roll over to zero after the limit value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_addr_gen.sv
// Convolution sequencer: validates the latched layer configuration, then walks
// co/oy/ox/ci/ky/kx and streams one feature and one kernel word address per
// tap. Addresses are tracked incrementally so the per-beat path is adders only.
//
// Stream handshake: a beat transfers on a cycle where rd_valid && rd_ready.
// rd_valid stays high for the whole RUN phase, and every rd_* output holds
// stable while rd_valid && !rd_ready.
module conv_addr_gen
  import conv_addr_gen_pkg::*;
#(
  parameter int ADDR_W = XLEN,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] kernel_baseaddr,
  input  logic [ADDR_W-1:0] feature_baseaddr,
  input  logic [ADDR_W-1:0] feature_width,
  input  logic [ADDR_W-1:0] feature_height,
  input  logic [ADDR_W-1:0] feature_chin,
  input  logic [ADDR_W-1:0] feature_chout,
  input  logic [ADDR_W-1:0] output_width,
  input  logic [ADDR_W-1:0] output_height,
  input  logic [7:0]        kernel_size,
  input  logic [7:0]        stride,
  input  logic [7:0]        padding,
  output logic              running,
  output logic              conv_done,
  output logic              exception,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_faddr,
  output logic [ADDR_W-1:0] rd_kaddr,
  output logic              rd_pad,
  output logic              rd_win_last,
  output logic              rd_last,
  output conv_state_e       dbg_state
);

  localparam int SW = CNT_W + 2;   // signed input-coordinate width
  localparam int WX = CNT_W + 10;  // width for the window-span check

  conv_state_e state;
  logic        start_q;

  logic [ADDR_W-1:0] cfg_kbase, cfg_fbase, cfg_w, cfg_h;
  logic [ADDR_W-1:0] cfg_cin, cfg_cout, cfg_ow, cfg_oh;
  logic [7:0]        cfg_k, cfg_s, cfg_p;

  logic start_rise, hs, cfg_bad, clr_cnt;
  logic win_last, last_beat;
  logic [N_LOOPS-1:0] en_c, mx, wr;
  logic [CNT_W-1:0]   lim [N_LOOPS];

  // Current input coordinate and the window origin it is relative to.
  logic signed [SW-1:0] oys, oxs, iy, ix;
  logic signed [SW-1:0] p_s, s_s, h_s, w_s;
  // Running address components: row (iy*W), channel (ci*H*W), kernel.
  logic [ADDR_W-1:0] oy_row, row_off, ch_off, kaddr, kco;
  // Per-layer step sizes, captured once in CHECK.
  logic [ADDR_W-1:0] hw, sw, win_len;
  logic [ADDR_W-1:0] hw_c, sw_c, pw_c, win_len_c, faddr_c;
  logic              pad_c;
  logic [WX-1:0]     span_x, span_y, room_x, room_y;
  logic              dim_zero, dim_big;

  assign start_rise = start & ~start_q;
  assign hs         = rd_valid & rd_ready;
  assign clr_cnt    = (state == ST_CHECK);
  assign dbg_state  = state;

  // Configuration validity, evaluated on the latched fields during CHECK.
  assign dim_zero = (cfg_k == '0) || (cfg_s == '0) || (cfg_w == '0) || (cfg_h == '0)
                 || (cfg_cin == '0) || (cfg_cout == '0) || (cfg_ow == '0) || (cfg_oh == '0);
  assign dim_big  = (|cfg_w[ADDR_W-1:CNT_W]) || (|cfg_h[ADDR_W-1:CNT_W])
                 || (|cfg_cin[ADDR_W-1:CNT_W]) || (|cfg_cout[ADDR_W-1:CNT_W])
                 || (|cfg_ow[ADDR_W-1:CNT_W]) || (|cfg_oh[ADDR_W-1:CNT_W]);
  assign span_x = (WX'(cfg_ow[CNT_W-1:0]) - WX'(1)) * WX'(cfg_s) + WX'(cfg_k);
  assign span_y = (WX'(cfg_oh[CNT_W-1:0]) - WX'(1)) * WX'(cfg_s) + WX'(cfg_k);
  assign room_x = WX'(cfg_w[CNT_W-1:0]) + (WX'(cfg_p) << 1);
  assign room_y = WX'(cfg_h[CNT_W-1:0]) + (WX'(cfg_p) << 1);
  assign cfg_bad = dim_zero || dim_big || (span_x > room_x) || (span_y > room_y);

  // One-time products used to seed the incremental address registers.
  assign hw_c      = cfg_h * cfg_w;
  assign sw_c      = ADDR_W'(cfg_s) * cfg_w;
  assign pw_c      = ADDR_W'(cfg_p) * cfg_w;
  assign win_len_c = ADDR_W'(cfg_k) * ADDR_W'(cfg_k) * cfg_cin;

  assign p_s = SW'(cfg_p);
  assign s_s = SW'(cfg_s);
  assign h_s = SW'(cfg_h[CNT_W-1:0]);
  assign w_s = SW'(cfg_w[CNT_W-1:0]);

  // Loop limits, innermost first: kx, ky, ci, ox, oy, co.
  assign lim[0] = CNT_W'(cfg_k) - CNT_W'(1);
  assign lim[1] = CNT_W'(cfg_k) - CNT_W'(1);
  assign lim[2] = cfg_cin[CNT_W-1:0]  - CNT_W'(1);
  assign lim[3] = cfg_ow[CNT_W-1:0]   - CNT_W'(1);
  assign lim[4] = cfg_oh[CNT_W-1:0]   - CNT_W'(1);
  assign lim[5] = cfg_cout[CNT_W-1:0] - CNT_W'(1);

  // Each loop steps when the one inside it wraps; the innermost on a handshake.
  assign en_c = {wr[N_LOOPS-2:0], hs};

  for (genvar i = 0; i < N_LOOPS; i++) begin : g_cnt
    conv_loop_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .en    (en_c[i]),
      .limit (lim[i]),
      .max   (mx[i]),
      .wrap  (wr[i])
    );
  end

  assign win_last  = mx[0] & mx[1] & mx[2];
  assign last_beat = win_last & mx[3] & mx[4] & mx[5];

  assign pad_c   = iy[SW-1] || (iy >= h_s) || ix[SW-1] || (ix >= w_s);
  assign faddr_c = cfg_fbase + ch_off + row_off + ADDR_W'(ix);

  assign rd_faddr    = (rd_valid && !pad_c) ? faddr_c : '0;
  assign rd_kaddr    = rd_valid ? kaddr : '0;
  assign rd_pad      = rd_valid & pad_c;
  assign rd_win_last = rd_valid & win_last;
  assign rd_last     = rd_valid & last_beat;

  // Sequencer FSM: start edge, config latch/check, run until the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      running   <= 1'b0;
      conv_done <= 1'b0;
      exception <= 1'b0;
      rd_valid  <= 1'b0;
      cfg_kbase <= '0;
      cfg_fbase <= '0;
      cfg_w     <= '0;
      cfg_h     <= '0;
      cfg_cin   <= '0;
      cfg_cout  <= '0;
      cfg_ow    <= '0;
      cfg_oh    <= '0;
      cfg_k     <= '0;
      cfg_s     <= '0;
      cfg_p     <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state     <= ST_CHECK;
            running   <= 1'b1;
            conv_done <= 1'b0;
            exception <= 1'b0;
            cfg_kbase <= kernel_baseaddr;
            cfg_fbase <= feature_baseaddr;
            cfg_w     <= feature_width;
            cfg_h     <= feature_height;
            cfg_cin   <= feature_chin;
            cfg_cout  <= feature_chout;
            cfg_ow    <= output_width;
            cfg_oh    <= output_height;
            cfg_k     <= kernel_size;
            cfg_s     <= stride;
            cfg_p     <= padding;
          end
        end
        ST_CHECK: begin
          if (cfg_bad) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            exception <= 1'b1;
          end else begin
            state    <= ST_RUN;
            rd_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wr[N_LOOPS-1]) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            rd_valid  <= 1'b0;
            conv_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address datapath: seed in CHECK, then step per accepted beat with adders.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oys     <= '0;
      oxs     <= '0;
      iy      <= '0;
      ix      <= '0;
      oy_row  <= '0;
      row_off <= '0;
      ch_off  <= '0;
      kaddr   <= '0;
      kco     <= '0;
      hw      <= '0;
      sw      <= '0;
      win_len <= '0;
    end else if (state == ST_CHECK) begin
      hw      <= hw_c;
      sw      <= sw_c;
      win_len <= win_len_c;
      oys     <= -p_s;
      oxs     <= -p_s;
      iy      <= -p_s;
      ix      <= -p_s;
      oy_row  <= -pw_c;
      row_off <= -pw_c;
      ch_off  <= '0;
      kaddr   <= cfg_kbase;
      kco     <= cfg_kbase;
    end else if (hs) begin
      // Feature coordinate: the innermost loop that does not wrap decides.
      if (!mx[0]) begin
        ix <= ix + SW'(1);
      end else if (!mx[1]) begin
        ix      <= oxs;
        iy      <= iy + SW'(1);
        row_off <= row_off + cfg_w;
      end else if (!mx[2]) begin
        ix      <= oxs;
        iy      <= oys;
        row_off <= oy_row;
        ch_off  <= ch_off + hw;
      end else if (!mx[3]) begin
        oxs     <= oxs + s_s;
        ix      <= oxs + s_s;
        iy      <= oys;
        row_off <= oy_row;
        ch_off  <= '0;
      end else if (!mx[4]) begin
        oxs     <= -p_s;
        ix      <= -p_s;
        oys     <= oys + s_s;
        iy      <= oys + s_s;
        oy_row  <= oy_row + sw;
        row_off <= oy_row + sw;
        ch_off  <= '0;
      end else begin
        oxs     <= -p_s;
        ix      <= -p_s;
        oys     <= -p_s;
        iy      <= -p_s;
        oy_row  <= -(cfg_p * cfg_w);
        row_off <= -(cfg_p * cfg_w);
        ch_off  <= '0;
      end
      // Kernel address runs linearly through one window, then rewinds to the
      // current output channel's block, or advances a block when co steps.
      if (!win_last) begin
        kaddr <= kaddr + ADDR_W'(1);
      end else if (!(mx[3] && mx[4])) begin
        kaddr <= kco;
      end else begin
        kco   <= kco + win_len;
        kaddr <= kco + win_len;
      end
    end
  end

endmodule

// File: doc/conv_addr_gen.md
# conv_addr_gen

Convolution sequencer and window address generator sitting directly downstream of the AXI CSR block inside `accelerator`. It consumes the CSR layer configuration and `start`, and drives the `running`/`conv_done`/`exception` status bits back to the CSR. It walks every output pixel's receptive field and emits one feature-SRAM and one kernel-SRAM word address per tap over a valid/ready stream, flagging padding taps, for the MAC datapath that follows.

## Interface
Parameters:
- `ADDR_W`, default `XLEN` (32): address and CSR field width.
- `CNT_W`, default 16: loop counter width; every dimension must fit in it.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  CSR start bit; the rising edge is acted on.
- `kernel_baseaddr`, `feature_baseaddr`  in  ADDR_W  word base addresses.
- `feature_width`, `feature_height`, `feature_chin`, `feature_chout`  in  ADDR_W  W, H, Cin, Cout.
- `output_width`, `output_height`  in  ADDR_W  OW, OH.
- `kernel_size`, `stride`, `padding`  in  8  K, S, P.
- `running`  out  1  layer in progress.
- `conv_done`  out  1  sticky completion flag.
- `exception`  out  1  sticky configuration error.
- `rd_valid`  out  1  tap beat valid.
- `rd_ready`  in  1  downstream accepts beat.
- `rd_faddr`  out  ADDR_W  feature word address; 0 when padded.
- `rd_kaddr`  out  ADDR_W  kernel word address.
- `rd_pad`  out  1  tap lies in padding; data must be treated as zero.
- `rd_win_last`  out  1  last tap of the current output pixel.
- `rd_last`  out  1  final beat of the layer.

## Operation
- FSM states: IDLE, CHECK, RUN.
  - IDLE to CHECK: on the rising edge of `start` (registered `start` delay). At this point `conv_done` and `exception` clear, and all config fields are latched into internal registers.
  - CHECK is a single cycle. It sets `exception` and returns to IDLE if any of the following hold:
    - K, S, W, H, Cin, Cout, OW or OH is 0;
    - any dimension is at least 2^CNT_W;
    - (OW−1)·S+K > W+2P, or (OH−1)·S+K > H+2P.
  - Otherwise CHECK moves to RUN.
  - RUN to IDLE: on the handshake of the `rd_last` beat, `conv_done` is set.
- Loop order, outermost first: co, oy, ox, ci, ky, kx. Counters advance only on a `rd_valid && rd_ready` handshake.
- Total beats = Cout·OH·OW·Cin·K·K.
- Address arithmetic (unsigned, wraps modulo 2^ADDR_W):
  - iy = oy·S+ky−P and ix = ox·S+kx−P, computed signed with CNT_W+2 bits.
  - `rd_pad` = (iy<0) | (iy≥H) | (ix<0) | (ix≥W).
  - `rd_faddr` = feature_baseaddr + (ci·H+iy)·W+ix.
  - `rd_kaddr` = kernel_baseaddr + ((co·Cin+ci)·K+ky)·K+kx.
  - Incremental (adder-only) computation is required in RUN. No multipliers on the per-beat path.
- `rd_win_last` = (ci=Cin−1 & ky=K−1 & kx=K−1). `rd_last` = `rd_win_last` & co, oy and ox all at their maximum.
- `running` = 1 in CHECK and RUN.
- A `start` edge during CHECK or RUN is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- `start` rises at edge t. The FSM is in CHECK from t+1 and RUN from t+2. The first `rd_valid` is at t+2. `exception` is visible at t+2 on an error path.
- In RUN, `rd_valid` stays high continuously. Throughput is 1 beat/cycle when `rd_ready`=1.
- While `rd_valid && !rd_ready`, all `rd_*` outputs hold stable.
- After the `rd_last` handshake: `rd_valid`=0, `running`=0 and `conv_done`=1 on the next cycle.
- `rst_n` asserted mid-RUN aborts immediately. All outputs go to 0 and `conv_done` is not set.

## Structure
- The shared package (`defines.sv`/pkg) holds the FSM state enum `conv_state_e` and the `CNT_W` constant.
- One natural sub-module: `conv_loop_cnt`, a parametric wrap counter with `en`, `max`, `wrap` outputs, instantiated six times and chained by `wrap`.

## Test plan
- W=H=4, Cin=Cout=1, K=3, S=1, P=0, OW=OH=2, rd_ready=1:
  - 36 beats with no pads;
  - first window faddr = base+{0,1,2,4,5,6,8,9,10};
  - last beat faddr = base+15 with `rd_last`=1;
  - `conv_done` rises the cycle after the last beat.
- W=H=2, K=3, S=1, P=1, OW=OH=2: first window `rd_pad` = 1,1,1,1,0,0,1,0,0 with non-pad faddr base+0, base+1, base+2, base+3; padded faddr = 0.
- W=5, H=3, K=3, S=2, P=0, OW=2, OH=1: second window starts at faddr base+2. Cin=2, Cout=2 checks that kaddr for co=1, ci=0, tap 0 = kbase+18.
- Stride=0, or OW=3 with W=4, K=3, P=0: `exception`=1 at t+2, `running` low after CHECK, no `rd_valid`, `conv_done`=0.
- Random `rd_ready` backpressure, including 3 consecutive stalls mid-window: address and flag sequence identical to the unstalled run, and outputs stable during stalls.
- `rst_n` low mid-RUN: all outputs 0 immediately. A fresh `start` edge then runs the full sequence from beat 0.
